// File: rtl/cpu_idecode_pkg.sv
// Shared definitions for the RV32I decode stage.
// Contents: opcode-class enum driven on d_op, RV32I major opcodes,
// SYSTEM funct12 codes that halt the core, FSM state type, the
// registered decode packet layout and the opcode classifier.
package cpu_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    typedef enum logic [3:0] {
        OP_LUI     = 4'd0,
        OP_AUIPC   = 4'd1,
        OP_JAL     = 4'd2,
        OP_JALR    = 4'd3,
        OP_BRANCH  = 4'd4,
        OP_LOAD    = 4'd5,
        OP_STORE   = 4'd6,
        OP_OPIMM   = 4'd7,
        OP_OP      = 4'd8,
        OP_FENCE   = 4'd9,
        OP_SYSTEM  = 4'd10,
        OP_ILLEGAL = 4'd15
    } op_e;

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_FENCE  = 7'h0F;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    localparam logic [11:0] F12_ECALL  = 12'h000;
    localparam logic [11:0] F12_EBREAK = 12'h001;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_e;

    // Reset value '0 gives d_op = OP_LUI and all fields zero.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        op_e             op;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [2:0]      funct3;
        logic            funct7b5;
    } pkt_t;

    // Any encoding without the 32-bit length marker (bits [1:0] = 11)
    // is illegal, as is any unknown major opcode.
    function automatic op_e decode_op(input logic [6:0] opc);
        op_e res;
        res = OP_ILLEGAL;
        if (opc[1:0] == 2'b11) begin
            case (opc)
                OPC_LUI:    res = OP_LUI;
                OPC_AUIPC:  res = OP_AUIPC;
                OPC_JAL:    res = OP_JAL;
                OPC_JALR:   res = OP_JALR;
                OPC_BRANCH: res = OP_BRANCH;
                OPC_LOAD:   res = OP_LOAD;
                OPC_STORE:  res = OP_STORE;
                OPC_OPIMM:  res = OP_OPIMM;
                OPC_OP:     res = OP_OP;
                OPC_FENCE:  res = OP_FENCE;
                OPC_SYSTEM: res = OP_SYSTEM;
                default:    res = OP_ILLEGAL;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/cpu_idecode_if.sv
// Decode-stage bus: fetch handshake (f_*), execute handshake and
// decode packet (x_*, d_*), and the writeback port (w_*).
// master: the environment around decode (fetch/execute/writeback).
// slave:  the decode stage itself.
interface cpu_idecode_if;
    import cpu_pkg::*;

    logic        f_valid;
    logic [31:0] f_instr;
    logic [31:0] f_pc;
    logic        f_rdy;
    logic        x_rdy;
    logic        x_flush;
    logic        w_en;
    logic [4:0]  w_rd;
    logic [31:0] w_data;
    logic        d_valid;
    logic [31:0] d_pc;
    op_e         d_op;
    logic [4:0]  d_rd;
    logic [4:0]  d_rs1;
    logic [4:0]  d_rs2;
    logic [31:0] d_rs1_val;
    logic [31:0] d_rs2_val;
    logic [31:0] d_imm;
    logic [2:0]  d_funct3;
    logic        d_funct7b5;
    logic        d_halted;

    modport master (
        output f_valid, f_instr, f_pc, x_rdy, x_flush, w_en, w_rd, w_data,
        input  f_rdy, d_valid, d_pc, d_op, d_rd, d_rs1, d_rs2,
               d_rs1_val, d_rs2_val, d_imm, d_funct3, d_funct7b5, d_halted
    );

    modport slave (
        input  f_valid, f_instr, f_pc, x_rdy, x_flush, w_en, w_rd, w_data,
        output f_rdy, d_valid, d_pc, d_op, d_rd, d_rs1, d_rs2,
               d_rs1_val, d_rs2_val, d_imm, d_funct3, d_funct7b5, d_halted
    );

endinterface

// File: rtl/cpu_idecode_regfile.sv
// 32x32 architectural register file.
// Ports: clk, rst_n (async, active-low, clears all entries);
// we/waddr/wdata synchronous write; raddr1/raddr2 -> rdata1/rdata2
// asynchronous reads. x0 reads zero and ignores writes.
module cpu_regfile
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [NREGS-1:0][XLEN-1:0] regs_q;
    logic [NREGS-1:0][XLEN-1:0] regs_d;

    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != 5'd0)) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? '0 : regs_q[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/cpu_idecode.sv
// RV32I decode stage.
// Ports: clk, rst_n (async, active-low); bus (cpu_idecode_if.slave):
// fetch handshake f_valid/f_instr/f_pc/f_rdy, execute handshake
// x_rdy/x_flush, writeback w_en/w_rd/w_data, registered packet d_*,
// and d_halted while stopped on ECALL/EBREAK.
module cpu_idecode
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    cpu_idecode_if.slave  bus
);

    logic [31:0] instr;
    op_e         op;
    logic        use_rd, use_rs1, use_rs2;
    logic [31:0] imm;
    logic [4:0]  dec_rs1, dec_rs2;
    logic [31:0] rf_rd1, rf_rd2;
    logic        is_halt;
    logic        f_rdy;
    logic        capture;
    pkt_t        dec_pkt;

    state_e      state_q, state_d;
    logic        valid_q, valid_d;
    pkt_t        pkt_q,   pkt_d;

    assign instr = bus.f_instr;
    assign op    = decode_op(instr[6:0]);

    // Format-dependent field usage and immediate selection.
    always_comb begin
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        imm     = '0;
        case (op)
            OP_LUI, OP_AUIPC: begin
                use_rd = 1'b1;
                imm    = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
                use_rd = 1'b1;
                imm    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
            end
            OP_JALR, OP_LOAD, OP_OPIMM, OP_SYSTEM: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                imm     = {{20{instr[31]}}, instr[31:20]};
            end
            OP_FENCE: begin
                imm = {{20{instr[31]}}, instr[31:20]};
            end
            OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                           instr[11:8], 1'b0};
            end
            OP_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_OP: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign dec_rs1 = use_rs1 ? instr[19:15] : 5'd0;
    assign dec_rs2 = use_rs2 ? instr[24:20] : 5'd0;

    cpu_regfile u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (bus.w_en),
        .waddr  (bus.w_rd),
        .wdata  (bus.w_data),
        .raddr1 (dec_rs1),
        .raddr2 (dec_rs2),
        .rdata1 (rf_rd1),
        .rdata2 (rf_rd2)
    );

    assign is_halt = (op == OP_SYSTEM) && (instr[14:12] == 3'd0) &&
                     ((instr[31:20] == F12_ECALL) || (instr[31:20] == F12_EBREAK));

    assign f_rdy   = bus.x_rdy && (state_q == S_RUN);
    assign capture = bus.f_valid && f_rdy;

    // Writeback landing in the capture cycle is not yet in the array,
    // so it is forwarded straight into the packet.
    always_comb begin
        dec_pkt          = '0;
        dec_pkt.pc       = bus.f_pc;
        dec_pkt.op       = op;
        dec_pkt.rd       = use_rd ? instr[11:7] : 5'd0;
        dec_pkt.rs1      = dec_rs1;
        dec_pkt.rs2      = dec_rs2;
        dec_pkt.rs1_val  = (bus.w_en && (bus.w_rd == dec_rs1) && (dec_rs1 != 5'd0))
                           ? bus.w_data : rf_rd1;
        dec_pkt.rs2_val  = (bus.w_en && (bus.w_rd == dec_rs2) && (dec_rs2 != 5'd0))
                           ? bus.w_data : rf_rd2;
        dec_pkt.imm      = imm;
        dec_pkt.funct3   = instr[14:12];
        dec_pkt.funct7b5 = instr[30];
    end

    // Held packets keep tracking writeback to their source registers so
    // the operands are current whenever execute finally accepts them.
    // Flush wins over capture and also cancels a halt.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        pkt_d   = pkt_q;
        if (bus.w_en && (bus.w_rd != 5'd0) && (bus.w_rd == pkt_q.rs1)) begin
            pkt_d.rs1_val = bus.w_data;
        end
        if (bus.w_en && (bus.w_rd != 5'd0) && (bus.w_rd == pkt_q.rs2)) begin
            pkt_d.rs2_val = bus.w_data;
        end
        if (bus.x_flush) begin
            valid_d = 1'b0;
            state_d = S_RUN;
        end else if (capture) begin
            pkt_d   = dec_pkt;
            valid_d = 1'b1;
            if (is_halt) begin
                state_d = S_HALT;
            end
        end else if (bus.x_rdy) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            valid_q <= 1'b0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            pkt_q   <= pkt_d;
        end
    end

    assign bus.f_rdy      = f_rdy;
    assign bus.d_valid    = valid_q;
    assign bus.d_pc       = pkt_q.pc;
    assign bus.d_op       = pkt_q.op;
    assign bus.d_rd       = pkt_q.rd;
    assign bus.d_rs1      = pkt_q.rs1;
    assign bus.d_rs2      = pkt_q.rs2;
    assign bus.d_rs1_val  = pkt_q.rs1_val;
    assign bus.d_rs2_val  = pkt_q.rs2_val;
    assign bus.d_imm      = pkt_q.imm;
    assign bus.d_funct3   = pkt_q.funct3;
    assign bus.d_funct7b5 = pkt_q.funct7b5;
    assign bus.d_halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_idecode.sv
// Bench for cpu_idecode: directed instruction vectors, expected packets
// queued at issue time and compared by a monitor on acceptance.
module tb_cpu_idecode;
    import cpu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_idecode_if bus();

    cpu_idecode dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic        f7;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_pkt(input logic [31:0] pc, input op_e op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] v1, input logic [31:0] v2,
                              input logic [31:0] imm, input logic [2:0] f3, input logic f7);
        exp_t e;
        e.pc = pc; e.op = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
        e.v1 = v1; e.v2 = v2; e.imm = imm; e.f3 = f3; e.f7 = f7;
        sb.push_back(e);
    endtask

    // Inputs change 1 time unit after a rising edge and are sampled at the next one.
    task automatic drive(input logic fv, input logic [31:0] ins, input logic [31:0] pc,
                         input logic xr, input logic fl, input logic we,
                         input logic [4:0] wrd, input logic [31:0] wd);
        bus.f_valid = fv;  bus.f_instr = ins; bus.f_pc = pc;
        bus.x_rdy   = xr;  bus.x_flush = fl;
        bus.w_en    = we;  bus.w_rd    = wrd; bus.w_data = wd;
        @(posedge clk);
        #1;
    endtask

    // A packet counts as delivered when it is valid, execute is ready and
    // no flush squashes it.
    always @(negedge clk) begin
        if (rst_n && bus.d_valid && bus.x_rdy && !bus.x_flush) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pkt: pc 0x%08h delivered, none expected", bus.d_pc);
            end else begin
                mon_e = sb.pop_front();
                check("pkt_pc",   bus.d_pc, mon_e.pc);
                check("pkt_op",   {28'd0, bus.d_op}, {28'd0, mon_e.op});
                check("pkt_rd",   {27'd0, bus.d_rd}, {27'd0, mon_e.rd});
                check("pkt_rs1",  {27'd0, bus.d_rs1}, {27'd0, mon_e.rs1});
                check("pkt_rs2",  {27'd0, bus.d_rs2}, {27'd0, mon_e.rs2});
                check("pkt_rs1v", bus.d_rs1_val, mon_e.v1);
                check("pkt_rs2v", bus.d_rs2_val, mon_e.v2);
                check("pkt_imm",  bus.d_imm, mon_e.imm);
                check("pkt_f3",   {29'd0, bus.d_funct3}, {29'd0, mon_e.f3});
                check("pkt_f7b5", {31'd0, bus.d_funct7b5}, {31'd0, mon_e.f7});
            end
        end
    end

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: stimulus did not complete, time %0t", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        bus.f_valid = 1'b0; bus.f_instr = '0; bus.f_pc = '0;
        bus.x_rdy   = 1'b0; bus.x_flush = 1'b0;
        bus.w_en    = 1'b0; bus.w_rd    = '0; bus.w_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_d_valid",  {31'd0, bus.d_valid}, 32'd0);
        check("rst_d_halted", {31'd0, bus.d_halted}, 32'd0);
        check("rst_d_op",     {28'd0, bus.d_op}, 32'd0);
        check("rst_d_pc",     bus.d_pc, 32'd0);
        check("rst_d_imm",    bus.d_imm, 32'd0);
        check("rst_f_rdy_lo", {31'd0, bus.f_rdy}, 32'd0);
        bus.x_rdy = 1'b1;
        #1;
        check("rst_f_rdy_hi", {31'd0, bus.f_rdy}, 32'd1);
        rst_n = 1'b1;

        // Seed registers.
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_1234);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_0055);

        // Back-to-back stream: addi, sw, beq, lui, jal.
        expect_pkt(32'h00, OP_OPIMM, 5'd6, 5'd5, 5'd0, 32'h1234, 32'h0, 32'hFFFF_FFFF, 3'd0, 1'b1);
        drive(1'b1, 32'hFFF2_8313, 32'h00, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        check("stream_f_rdy", {31'd0, bus.f_rdy}, 32'd1);
        expect_pkt(32'h04, OP_STORE, 5'd0, 5'd5, 5'd7, 32'h1234, 32'h55, 32'hFFFF_FFF4, 3'd2, 1'b1);
        drive(1'b1, 32'hFE72_AA23, 32'h04, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        expect_pkt(32'h08, OP_BRANCH, 5'd0, 5'd5, 5'd7, 32'h1234, 32'h55, 32'hFFFF_FFFC, 3'd0, 1'b1);
        drive(1'b1, 32'hFE72_8EE3, 32'h08, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        expect_pkt(32'h0C, OP_LUI, 5'd10, 5'd0, 5'd0, 32'h0, 32'h0, 32'hABCD_E000, 3'd6, 1'b0);
        drive(1'b1, 32'hABCD_E537, 32'h0C, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        expect_pkt(32'h10, OP_JAL, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0000_0800, 3'd0, 1'b0);
        drive(1'b1, 32'h0010_00EF, 32'h10, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);

        // add x11, x12, x5 with x12 written in the capture cycle.
        expect_pkt(32'h14, OP_OP, 5'd11, 5'd12, 5'd5, 32'hCAFE_0001, 32'h1234, 32'h0, 3'd0, 1'b0);
        drive(1'b1, 32'h0056_05B3, 32'h14, 1'b1, 1'b0, 1'b1, 5'd12, 32'hCAFE_0001);

        // add x13, x5, x14 then a 3-cycle stall; x14 written mid-stall.
        expect_pkt(32'h18, OP_OP, 5'd13, 5'd5, 5'd14, 32'h1234, 32'h77, 32'h0, 3'd0, 1'b0);
        drive(1'b1, 32'h00E2_86B3, 32'h18, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        drive(1'b1, 32'h0030_0793, 32'h1C, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_FFFF);
        check("stall1_f_rdy", {31'd0, bus.f_rdy}, 32'd0);
        check("stall1_pc",    bus.d_pc, 32'h18);
        check("stall1_rs2v",  bus.d_rs2_val, 32'h0);
        drive(1'b1, 32'h0030_0793, 32'h1C, 1'b0, 1'b0, 1'b1, 5'd14, 32'h0000_0077);
        check("stall2_rs2v",  bus.d_rs2_val, 32'h77);
        check("stall2_pc",    bus.d_pc, 32'h18);
        check("stall2_rd",    {27'd0, bus.d_rd}, 32'd13);
        check("stall2_f_rdy", {31'd0, bus.f_rdy}, 32'd0);
        drive(1'b1, 32'h0030_0793, 32'h1C, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        check("stall3_rs1v",  bus.d_rs1_val, 32'h1234);
        check("stall3_valid", {31'd0, bus.d_valid}, 32'd1);

        // addi x15, x0, 3 with a concurrent write to x0.
        expect_pkt(32'h1C, OP_OPIMM, 5'd15, 5'd0, 5'd0, 32'h0, 32'h0, 32'h3, 3'd0, 1'b0);
        drive(1'b1, 32'h0030_0793, 32'h1C, 1'b1, 1'b0, 1'b1, 5'd0, 32'h0000_BEEF);

        // ECALL halts after issue.
        expect_pkt(32'h20, OP_SYSTEM, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0);
        drive(1'b1, 32'h0000_0073, 32'h20, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        check("ecall_halted", {31'd0, bus.d_halted}, 32'd1);
        check("ecall_f_rdy",  {31'd0, bus.f_rdy}, 32'd0);
        check("ecall_valid",  {31'd0, bus.d_valid}, 32'd1);
        drive(1'b1, 32'h0000_007F, 32'h24, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        check("halt_valid",   {31'd0, bus.d_valid}, 32'd0);
        check("halt_halted",  {31'd0, bus.d_halted}, 32'd1);
        check("halt_pc",      bus.d_pc, 32'h20);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
        check("unhalt_halted", {31'd0, bus.d_halted}, 32'd0);
        check("unhalt_f_rdy",  {31'd0, bus.f_rdy}, 32'd1);

        // Undefined opcode.
        expect_pkt(32'h24, OP_ILLEGAL, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0);
        drive(1'b1, 32'h0000_007F, 32'h24, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);

        // EBREAK captured together with flush: squashed, no halt.
        drive(1'b1, 32'h0010_0073, 32'h28, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
        check("flushcap_valid",  {31'd0, bus.d_valid}, 32'd0);
        check("flushcap_halted", {31'd0, bus.d_halted}, 32'd0);
        check("flushcap_f_rdy",  {31'd0, bus.f_rdy}, 32'd1);

        expect_pkt(32'h2C, OP_OPIMM, 5'd6, 5'd5, 5'd0, 32'h1234, 32'h0, 32'hFFFF_FFFF, 3'd0, 1'b1);
        drive(1'b1, 32'hFFF2_8313, 32'h2C, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);

        // Reset asserted while a packet is stalled.
        drive(1'b1, 32'hFFF2_8313, 32'h30, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, bus.d_valid}, 32'd0);
        check("arst_pc",    bus.d_pc, 32'h0);
        check("arst_rs1v",  bus.d_rs1_val, 32'h0);
        bus.x_rdy = 1'b1;
        #1;
        check("arst_f_rdy", {31'd0, bus.f_rdy}, 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        // x5 was cleared by reset.
        expect_pkt(32'h40, OP_OPIMM, 5'd6, 5'd5, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFFF, 3'd0, 1'b1);
        drive(1'b1, 32'hFFF2_8313, 32'h40, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        check("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
